// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared state type, mode/CTL codes and phase lengths for the HDMI period scheduler
//
// Build option: HDMI_DATA_ISLAND_EN. When it is defined, the data-island states are part of
// period_state_t. When it is undefined, only the DVI control/video states exist.
// No ports (package).

package hdmi_pkg;

  // Fixed phase lengths, in pixel clocks
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  // Span of a single-packet island: preamble, leading guard, packet and trailing guard.
  localparam int ISLAND_LEN   = PREAMBLE_LEN + GUARD_LEN + PACKET_LEN + GUARD_LEN;
  // Control columns needed after the last cycle of a packet to fit one more packet
  // plus the trailing guard band.
  localparam int PACKET_TAIL  = PACKET_LEN + GUARD_LEN + 1;

  // Encoder mode select shared by the three TMDS channels
  localparam logic [2:0] MODE_CTRL         = 3'd0;
  localparam logic [2:0] MODE_VIDEO        = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND       = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  // CTL0..CTL3 preamble patterns
  localparam logic [3:0] CTL_NONE       = 4'b0000;
  localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

  typedef enum logic [2:0] {
    ST_CTRL    = 3'd0,
    ST_VID_PRE = 3'd1,
    ST_VID_GB  = 3'd2,
    ST_VIDEO   = 3'd3
`ifdef HDMI_DATA_ISLAND_EN
    ,
    ST_DI_PRE  = 3'd4,
    ST_DI_LGB  = 3'd5,
    ST_DI_PKT  = 3'd6,
    ST_DI_TGB  = 3'd7
`endif
  } period_state_t;

  function automatic logic [2:0] mode_of(input period_state_t st);
    logic [2:0] m;
    m = MODE_CTRL;
    case (st)
      ST_VID_GB: m = MODE_VIDEO_GUARD;
      ST_VIDEO:  m = MODE_VIDEO;
`ifdef HDMI_DATA_ISLAND_EN
      ST_DI_LGB: m = MODE_ISLAND_GUARD;
      ST_DI_TGB: m = MODE_ISLAND_GUARD;
      ST_DI_PKT: m = MODE_ISLAND;
`endif
      default:   m = MODE_CTRL;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] ctl_of(input period_state_t st);
    logic [3:0] c;
    c = CTL_NONE;
    case (st)
      ST_VID_PRE: c = CTL_VIDEO_PRE;
`ifdef HDMI_DATA_ISLAND_EN
      ST_DI_PRE:  c = CTL_ISLAND_PRE;
`endif
      default:    c = CTL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// rtl/hdmi_period_scheduler_if.sv - timing, packet handshake and encoder-control bundle of the scheduler
//
// Signals:
//   cx, cy        pixel column / line from the video timing generator
//   packet_valid  packet assembler holds a complete 32-cycle packet
//   packet_ready  one-cycle pulse: assembler starts presenting the packet
//   di_counter    bit index within the current packet
//   mode          shared TMDS encoder mode select
//   ctl           CTL0..CTL3 preamble bits
// Modports: master = scheduler side, slave = timing generator / assembler / encoder side.

interface hdmi_period_scheduler_if #(
  parameter int BIT_WIDTH  = 10,
  parameter int BIT_HEIGHT = 10
);

  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic                  packet_valid;
  logic                  packet_ready;
  logic [4:0]            di_counter;
  logic [2:0]            mode;
  logic [3:0]            ctl;

  modport master (
    input  cx,
    input  cy,
    input  packet_valid,
    output packet_ready,
    output di_counter,
    output mode,
    output ctl
  );

  modport slave (
    output cx,
    output cy,
    output packet_valid,
    input  packet_ready,
    input  di_counter,
    input  mode,
    input  ctl
  );

endinterface

// File: rtl/hdmi_period_scheduler_period_counter.sv
// rtl/hdmi_period_scheduler_period_counter.sv - loadable down-counter timing the fixed-length phases
//
// Ports:
//   clk_i         clock
//   resetn_i      synchronous active-low reset
//   load_i        load load_val_i this cycle (takes priority over counting)
//   load_val_i    cycles remaining after the first cycle of the new phase
//   count_next_o  value the counter takes at the next edge
//   zero_o        registered count is zero: the current phase is on its last cycle

module period_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_next_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Saturates at zero so idle states (CTRL, VIDEO) leave it parked.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;
  assign zero_o       = (count_q == '0);

endmodule

// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - decides per pixel whether the HDMI link carries control, preamble, guard, video or island symbols
//
// Build option: HDMI_DATA_ISLAND_EN. Defined: full HDMI with data islands. Undefined: DVI only,
// packet_ready and di_counter tied low, mode limited to control / video / video guard.
// Ports:
//   clk_pixel   pixel clock, rising edge
//   reset_n     synchronous active-low reset
//   bus         hdmi_period_scheduler_if.master: cx/cy/packet_valid in,
//               packet_ready/di_counter/mode/ctl out (all registered)
//
// Timing model: state_d is the period the current cx/cy belongs to; every output is
// registered from state_d, so the value seen one cycle later describes the sampled column.

module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int BIT_WIDTH      = 10,
  parameter int BIT_HEIGHT     = 10,
  parameter int FRAME_WIDTH    = 800,
  parameter int SCREEN_START_X = 160,
  parameter int SCREEN_START_Y = 45,
  parameter int DI_START_X     = 10,
  parameter int MAX_PACKETS    = 18
) (
  input logic                     clk_pixel,
  input logic                     reset_n,
  hdmi_period_scheduler_if.master bus
);

  localparam int CNT_W = 5;

  localparam logic [31:0] VID_PRE_X  = 32'(SCREEN_START_X - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [31:0] LAST_COL   = 32'(FRAME_WIDTH - 1);
  localparam logic [31:0] FIRST_LINE = 32'(SCREEN_START_Y);

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] PKT_LOAD   = CNT_W'(PACKET_LEN - 1);

  period_state_t    state_q;
  period_state_t    state_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [2:0]       mode_q;
  logic [3:0]       ctl_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_zero;

  logic [31:0]      cx_w;
  logic [31:0]      cy_w;
  logic             line_video;

  assign cx_w       = 32'(bus.cx);
  assign cy_w       = 32'(bus.cy);
  assign line_video = (cy_w >= FIRST_LINE);

`ifdef HDMI_DATA_ISLAND_EN
  // LIMIT keeps at least four control cycles ahead of the video preamble (or the wrap).
  localparam logic [31:0] LIMIT_VIDEO = 32'(SCREEN_START_X - 14);
  localparam logic [31:0] LIMIT_BLANK = 32'(FRAME_WIDTH - 4);
  localparam logic [31:0] DI_X        = 32'(DI_START_X);
  localparam logic [31:0] MAX_PKT     = 32'(MAX_PACKETS);

  logic [31:0]      limit;
  logic             island_ok;
  logic             start_pkt;
  logic [CNT_W-1:0] pkt_count_q;
  logic [CNT_W-1:0] pkt_count_d;
  logic             more_q;
  logic             more_d;
  logic             packet_ready_q;
  logic [4:0]       di_counter_q;
  logic [4:0]       di_counter_d;

  assign limit     = line_video ? LIMIT_VIDEO : LIMIT_BLANK;
  assign island_ok = bus.packet_valid && (cx_w >= DI_X) &&
                     (cx_w + 32'(ISLAND_LEN) <= limit);
`endif

  period_counter #(
    .WIDTH(CNT_W)
  ) u_period_counter (
    .clk_i       (clk_pixel),
    .resetn_i    (reset_n),
    .load_i      (cnt_load),
    .load_val_i  (cnt_load_val),
    .count_next_o(cnt_next),
    .zero_o      (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
`ifdef HDMI_DATA_ISLAND_EN
    start_pkt    = 1'b0;
    pkt_count_d  = pkt_count_q;
`endif
    case (state_q)
      ST_CTRL: begin
        // Video is tested first so it wins any (impossible by LIMIT) tie with an island.
        if (line_video && (cx_w == VID_PRE_X)) begin
          state_d      = ST_VID_PRE;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
        end
`ifdef HDMI_DATA_ISLAND_EN
        else if (island_ok) begin
          state_d      = ST_DI_PRE;
          cnt_load     = 1'b1;
          cnt_load_val = PRE_LOAD;
          pkt_count_d  = '0;
        end
`endif
      end
      ST_VID_PRE: begin
        if (cnt_zero) begin
          state_d      = ST_VID_GB;
          cnt_load     = 1'b1;
          cnt_load_val = GUARD_LOAD;
        end
      end
      ST_VID_GB: begin
        if (cnt_zero) begin
          state_d = ST_VIDEO;
        end
      end
      ST_VIDEO: begin
        // wrap_q marks that the previous column was the last of the line.
        if (wrap_q) begin
          state_d = ST_CTRL;
        end
      end
`ifdef HDMI_DATA_ISLAND_EN
      ST_DI_PRE: begin
        if (cnt_zero) begin
          state_d      = ST_DI_LGB;
          cnt_load     = 1'b1;
          cnt_load_val = GUARD_LOAD;
        end
      end
      ST_DI_LGB: begin
        if (cnt_zero) begin
          state_d   = ST_DI_PKT;
          start_pkt = 1'b1;
        end
      end
      ST_DI_PKT: begin
        // The follow-on decision was taken on the di_counter == 31 cycle (more_q).
        if (cnt_zero) begin
          if (more_q) begin
            start_pkt = 1'b1;
          end else begin
            state_d      = ST_DI_TGB;
            cnt_load     = 1'b1;
            cnt_load_val = GUARD_LOAD;
          end
        end
      end
      ST_DI_TGB: begin
        if (cnt_zero) begin
          state_d = ST_CTRL;
        end
      end
`endif
      default: begin
        state_d = ST_CTRL;
      end
    endcase
`ifdef HDMI_DATA_ISLAND_EN
    if (start_pkt) begin
      cnt_load     = 1'b1;
      cnt_load_val = PKT_LOAD;
      if (32'(pkt_count_q) < MAX_PKT) begin
        pkt_count_d = pkt_count_q + CNT_W'(1);
      end
    end
`endif
  end

  assign wrap_d = (state_d == ST_VIDEO) && (cx_w == LAST_COL);

`ifdef HDMI_DATA_ISLAND_EN
  // packet_valid is only looked at here and at island start; a drop mid-packet is ignored.
  assign more_d = (state_d == ST_DI_PKT) && (cnt_next == '0) && bus.packet_valid &&
                  (32'(pkt_count_d) < MAX_PKT) && (cx_w + 32'(PACKET_TAIL) <= limit);

  assign di_counter_d = (state_d == ST_DI_PKT) ? (PKT_LOAD - cnt_next) : '0;

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      pkt_count_q    <= '0;
      more_q         <= 1'b0;
      packet_ready_q <= 1'b0;
      di_counter_q   <= '0;
    end else begin
      pkt_count_q    <= pkt_count_d;
      more_q         <= more_d;
      packet_ready_q <= start_pkt;
      di_counter_q   <= di_counter_d;
    end
  end

  assign bus.packet_ready = packet_ready_q;
  assign bus.di_counter   = di_counter_q;
`else
  logic unused_dvi;
  assign unused_dvi = bus.packet_valid ^ (^cnt_next) ^ (DI_START_X != 0) ^ (MAX_PACKETS != 0);

  assign bus.packet_ready = 1'b0;
  assign bus.di_counter   = '0;
`endif

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q <= ST_CTRL;
      wrap_q  <= 1'b0;
      mode_q  <= MODE_CTRL;
      ctl_q   <= CTL_NONE;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_of(state_d);
      ctl_q   <= ctl_of(state_d);
    end
  end

  assign bus.mode = mode_q;
  assign bus.ctl  = ctl_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - directed self-checking bench for hdmi_period_scheduler

module tb_hdmi_period_scheduler;

  localparam int FW = 800;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  hdmi_period_scheduler_if #(.BIT_WIDTH(10), .BIT_HEIGHT(10)) ifa ();
  hdmi_period_scheduler_if #(.BIT_WIDTH(10), .BIT_HEIGHT(10)) ifb ();

  hdmi_period_scheduler dut_a (
    .clk_pixel(clk),
    .reset_n  (reset_n),
    .bus      (ifa)
  );

  hdmi_period_scheduler #(.MAX_PACKETS(2)) dut_b (
    .clk_pixel(clk),
    .reset_n  (reset_n),
    .bus      (ifb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Outputs observed for each sampled column (index = cx that produced them)
  int a_mode [FW];
  int a_ctl  [FW];
  int a_rdy  [FW];
  int a_di   [FW];
  int b_mode [FW];
  int b_ctl  [FW];
  int b_rdy  [FW];
  int b_di   [FW];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < FW; i++) begin
      a_mode[i] = -1; a_ctl[i] = -1; a_rdy[i] = -1; a_di[i] = -1;
      b_mode[i] = -1; b_ctl[i] = -1; b_rdy[i] = -1; b_di[i] = -1;
    end
  endtask

  task automatic step(input int x, input int y, input bit pv);
    ifa.cx = 10'(x); ifa.cy = 10'(y); ifa.packet_valid = pv;
    ifb.cx = 10'(x); ifb.cy = 10'(y); ifb.packet_valid = pv;
    @(posedge clk);
    #1;
    a_mode[x] = int'(ifa.mode); a_ctl[x] = int'(ifa.ctl);
    a_rdy[x]  = int'(ifa.packet_ready); a_di[x] = int'(ifa.di_counter);
    b_mode[x] = int'(ifb.mode); b_ctl[x] = int'(ifb.ctl);
    b_rdy[x]  = int'(ifb.packet_ready); b_di[x] = int'(ifb.di_counter);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic run_line(input int y, input int pv_on, input int pv_off, input int x_end);
    clear_obs();
    for (int x = 0; x <= x_end; x++) begin
      step(x, y, (x >= pv_on) && (x < pv_off));
    end
  endtask

  // Counts columns in [lo,hi] whose mode/ctl differ from the hand-derived pair.
  task automatic check_span(input string tag, input bit use_b, input int lo, input int hi,
                            input int m, input int c);
    int bad;
    int om;
    int oc;
    bad = 0;
    for (int x = lo; x <= hi; x++) begin
      om = use_b ? b_mode[x] : a_mode[x];
      oc = use_b ? b_ctl[x] : a_ctl[x];
      if ((om != m) || (oc != c)) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  function automatic int count_rdy(input bit use_b, input int lo, input int hi);
    int n;
    n = 0;
    for (int x = lo; x <= hi; x++) begin
      if ((use_b ? b_rdy[x] : a_rdy[x]) == 1) n++;
    end
    return n;
  endfunction

  initial begin
    ifa.cx = '0; ifa.cy = '0; ifa.packet_valid = 1'b0;
    ifb.cx = '0; ifb.cy = '0; ifb.packet_valid = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_mode", int'(ifa.mode), 0);
    check_eq("rst_ctl", int'(ifa.ctl), 0);
    check_eq("rst_ready", int'(ifa.packet_ready), 0);
    check_eq("rst_di", int'(ifa.di_counter), 0);

    // Video line timing, no packets
    do_reset();
    run_line(100, FW, FW, FW - 1);
    check_span("vid_ctrl_0_149", 1'b0, 0, 149, 0, 0);
    check_span("vid_pre_150_157", 1'b0, 150, 157, 0, 1);
    check_span("vid_gb_158_159", 1'b0, 158, 159, 2, 0);
    check_span("vid_act_160_799", 1'b0, 160, 799, 1, 0);
    check_eq("vid_mode_157", a_mode[157], 0);
    check_eq("vid_mode_158", a_mode[158], 2);
    check_eq("vid_mode_160", a_mode[160], 1);
    check_eq("vid_mode_799", a_mode[799], 1);
    check_eq("vid_ready_cnt", count_rdy(1'b0, 0, 799), 0);
    step(0, 101, 1'b0);
    check_eq("vid_wrap_mode_0", a_mode[0], 0);

    // Reset during video: forced to control, no re-entry
    do_reset();
    run_line(100, FW, FW, 170);
    check_eq("rstv_mode_170", a_mode[170], 1);
    reset_n = 1'b0;
    step(171, 100, 1'b0);
    reset_n = 1'b1;
    check_eq("rstv_mode_171", a_mode[171], 0);
    step(172, 100, 1'b0);
    check_eq("rstv_mode_172", a_mode[172], 0);

`ifdef HDMI_DATA_ISLAND_EN
    // Packet fitting: three packets, fourth refused by LIMIT
    do_reset();
    run_line(100, 10, FW, 160);
    check_span("pf_ctrl_0_9", 1'b0, 0, 9, 0, 0);
    check_span("pf_dipre_10_17", 1'b0, 10, 17, 0, 5);
    check_span("pf_lgb_18_19", 1'b0, 18, 19, 4, 0);
    check_span("pf_pkt_20_115", 1'b0, 20, 115, 3, 0);
    check_span("pf_tgb_116_117", 1'b0, 116, 117, 4, 0);
    check_span("pf_ctrl_118_149", 1'b0, 118, 149, 0, 0);
    check_span("pf_vidpre_150_157", 1'b0, 150, 157, 0, 1);
    check_span("pf_vidgb_158_159", 1'b0, 158, 159, 2, 0);
    check_eq("pf_ready_cnt", count_rdy(1'b0, 0, 160), 3);
    check_eq("pf_ready_20", a_rdy[20], 1);
    check_eq("pf_ready_52", a_rdy[52], 1);
    check_eq("pf_ready_84", a_rdy[84], 1);
    check_eq("pf_di_20", a_di[20], 0);
    check_eq("pf_di_51", a_di[51], 31);
    check_eq("pf_di_52", a_di[52], 0);
    check_eq("pf_di_115", a_di[115], 31);
    check_eq("pf_di_116", a_di[116], 0);

    // Blanking line: MAX_PACKETS = 2 on dut_b, 18 on dut_a
    do_reset();
    run_line(10, 10, 84, FW - 1);
    check_span("bl_b_dipre", 1'b1, 10, 17, 0, 5);
    check_span("bl_b_lgb", 1'b1, 18, 19, 4, 0);
    check_span("bl_b_pkt_20_83", 1'b1, 20, 83, 3, 0);
    check_span("bl_b_tgb_84_85", 1'b1, 84, 85, 4, 0);
    check_span("bl_b_ctrl_86_799", 1'b1, 86, 799, 0, 0);
    check_eq("bl_b_ready_cnt", count_rdy(1'b1, 0, 799), 2);
    check_eq("bl_b_di_83", b_di[83], 31);
    check_eq("bl_a_ready_cnt", count_rdy(1'b0, 0, 799), 3);
    check_span("bl_a_pkt_84_115", 1'b0, 84, 115, 3, 0);
    check_span("bl_a_tgb_116_117", 1'b0, 116, 117, 4, 0);
    check_span("bl_a_ctrl_118_799", 1'b0, 118, 799, 0, 0);

    // Mid-packet deassertion at di_counter = 5
    do_reset();
    run_line(100, 10, 25, 160);
    check_eq("md_di_25", a_di[25], 5);
    check_eq("md_di_51", a_di[51], 31);
    check_span("md_pkt_20_51", 1'b0, 20, 51, 3, 0);
    check_span("md_tgb_52_53", 1'b0, 52, 53, 4, 0);
    check_span("md_ctrl_54_149", 1'b0, 54, 149, 0, 0);
    check_eq("md_ready_cnt", count_rdy(1'b0, 0, 160), 1);

    // Late request on a video line
    do_reset();
    run_line(100, 103, FW, 160);
    check_span("late_ctrl_0_149", 1'b0, 0, 149, 0, 0);
    check_span("late_vidpre", 1'b0, 150, 157, 0, 1);
    check_eq("late_ready_cnt", count_rdy(1'b0, 0, 160), 0);

    // Reset during an island at di_counter = 12
    do_reset();
    run_line(100, 10, FW, 32);
    check_eq("ri_di_32", a_di[32], 12);
    check_eq("ri_mode_32", a_mode[32], 3);
    reset_n = 1'b0;
    step(33, 100, 1'b1);
    reset_n = 1'b1;
    check_eq("ri_mode_33", a_mode[33], 0);
    check_eq("ri_ctl_33", a_ctl[33], 0);
    check_eq("ri_di_33", a_di[33], 0);
    check_eq("ri_ready_33", a_rdy[33], 0);
    step(34, 100, 1'b0);
    step(35, 100, 1'b0);
    check_eq("ri_mode_34", a_mode[34], 0);
    check_eq("ri_mode_35", a_mode[35], 0);
`else
    // DVI build: packet requests are ignored entirely
    do_reset();
    run_line(100, 10, FW, 160);
    check_span("dvi_ctrl_0_149", 1'b0, 0, 149, 0, 0);
    check_span("dvi_vidpre", 1'b0, 150, 157, 0, 1);
    check_span("dvi_vidgb", 1'b0, 158, 159, 2, 0);
    check_eq("dvi_mode_160", a_mode[160], 1);
    check_eq("dvi_ready_cnt", count_rdy(1'b0, 0, 160), 0);
    check_eq("dvi_di_20", a_di[20], 0);
    do_reset();
    run_line(10, 10, FW, 200);
    check_span("dvi_blank_0_200", 1'b0, 0, 200, 0, 0);
    check_eq("dvi_blank_ready", count_rdy(1'b0, 0, 200), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
